// File: rtl/line_memory_responder.sv
// -----------------------------------------------------------------------------
// line_memory_responder
//   Data-memory responder for the D-cache line interface. Serves 4-word
//   (64-bit) line fills and write-backs with a fixed latency, and hands the
//   memory port to the DMA engine through a BR/BG handshake when the cache
//   is not using it.
//
// Ports
//   clk, reset_n             clock, synchronous active-low reset
//   mem_read_m, mem_write_m  cache line read / write request, held until ready
//   mem_addr                 word address, line aligned (bits [1:0] ignored)
//   mem_wdata / mem_rdata    line data, word0 in [15:0] .. word3 in [63:48]
//   mem_ready                one-cycle completion pulse
//   mem_busy                 request in flight, awaiting release, or DMA owns bus
//   dma_br / dma_bg          DMA bus request / grant
//   dma_we, dma_addr,
//   dma_wdata                DMA single-word write, honoured only while granted
//
// State | meaning
//   IDLE  | no owner; cache request wins over dma_br
//   BUSY  | cache request latched, counting to LATENCY
//   DONE  | ready issued, waiting for the cache to drop its request
//   GRANT | DMA owns the word array
// -----------------------------------------------------------------------------
module line_memory_responder #(
    parameter int LATENCY   = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [15:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    input  logic        dma_br,
    output logic        dma_bg,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, GRANT} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  count, count_next;
    logic [AW-3:0]  line_q, line_next;
    logic [63:0]    wdata_q, wdata_next;
    logic           op_rd_q, op_rd_next;
    logic           op_wr_q, op_wr_next;
    logic           ready_next, busy_next, bg_next;
    logic [63:0]    rdata_next;
    logic [63:0]    rd_line;
    logic           line_we;
    logic           dma_we_ok;

    logic [15:0]    mem [MEM_DEPTH];

    // Upper address bits wrap away; low bits of the cache address select
    // nothing because transfers are whole lines.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[15:AW], mem_addr[1:0], dma_addr[15:AW]};

    always_comb begin
        rd_line = '0;
        for (int i = 0; i < 4; i++) begin
            rd_line[16*i +: 16] = mem[{line_q, 2'(i)}];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            line_q    <= '0;
            wdata_q   <= '0;
            op_rd_q   <= 1'b0;
            op_wr_q   <= 1'b0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            dma_bg    <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            line_q    <= line_next;
            wdata_q   <= wdata_next;
            op_rd_q   <= op_rd_next;
            op_wr_q   <= op_wr_next;
            mem_ready <= ready_next;
            mem_busy  <= busy_next;
            dma_bg    <= bg_next;
            mem_rdata <= rdata_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        line_next  = line_q;
        wdata_next = wdata_q;
        op_rd_next = op_rd_q;
        op_wr_next = op_wr_q;
        ready_next = 1'b0;
        busy_next  = mem_busy;
        bg_next    = dma_bg;
        rdata_next = mem_rdata;
        line_we    = 1'b0;
        dma_we_ok  = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (mem_read_m || mem_write_m) begin
                    state_next = BUSY;
                    count_next = CW'(1);
                    line_next  = mem_addr[AW-1:2];
                    wdata_next = mem_wdata;
                    op_rd_next = mem_read_m;
                    op_wr_next = mem_write_m;
                    busy_next  = 1'b1;
                end else if (dma_br) begin
                    state_next = GRANT;
                    bg_next    = 1'b1;
                    busy_next  = 1'b1;
                end
            end
            BUSY: begin
                if (count == CW'(LATENCY)) begin
                    state_next = DONE;
                    ready_next = 1'b1;
                    line_we    = op_wr_q;
                    // A combined op returns the line it just wrote.
                    if (op_rd_q) begin
                        rdata_next = op_wr_q ? wdata_q : rd_line;
                    end
                end else begin
                    count_next = count + 1'b1;
                end
            end
            DONE: begin
                if (!mem_read_m && !mem_write_m) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            GRANT: begin
                if (!dma_br) begin
                    state_next = IDLE;
                    bg_next    = 1'b0;
                    busy_next  = 1'b0;
                end else begin
                    dma_we_ok = dma_we;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Array has no reset; commits are gated so a reset edge abandons them.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (line_we) begin
                for (int i = 0; i < 4; i++) begin
                    mem[{line_q, 2'(i)}] <= wdata_q[16*i +: 16];
                end
            end else if (dma_we_ok) begin
                mem[dma_addr[AW-1:0]] <= dma_wdata;
            end
        end
    end

endmodule
